// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  // Reset-default configuration for the classic 5-bit "10110" detector
  localparam logic [4:0] DEF_PATTERN_N5 = 5'b10110;
  localparam logic [4:0] DEF_MASK_N5    = 5'b11111;

  // Width needed to hold a fill count of 0..n
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Increment v, holding at 2^w-1 instead of wrapping (w up to 32)
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and fill counter for the pattern detector.
// Exposes the post-sample history/fill so the parent can compare against
// the bit arriving on this edge.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift,
  input  logic                 clear,
  input  logic                 restart,
  input  logic                 xin,
  output logic [fill_w(N)-1:0] fill,
  output logic [N-1:0]         next_hist,
  output logic [fill_w(N)-1:0] next_fill
);

  localparam int FW = fill_w(N);

  logic [N-1:0] hist;

  // Newest bit enters at bit 0; fill saturates once a full window is seen
  always_comb begin
    next_hist = {hist[N-2:0], xin};
    next_fill = (fill == FW'(N)) ? fill : fill + FW'(1);
  end

  // Clear beats shift; restart zeroes fill but still keeps the shifted history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= next_hist;
      fill <= restart ? '0 : next_fill;
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with run-time pattern/mask, overlap
// control, registered match pulse, saturating match counter and sticky hit.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int           N           = 5,
  parameter logic [N-1:0] DEF_PATTERN = N'(DEF_PATTERN_N5),
  parameter logic [N-1:0] DEF_MASK    = {N{1'b1}},
  parameter int           CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 xin,
  input  logic                 xin_valid,
  input  logic                 overlap_en,
  input  logic                 cfg_load,
  input  logic [N-1:0]         cfg_pattern,
  input  logic [N-1:0]         cfg_mask,
  input  logic                 clr_stat,
  output logic                 yout,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 hit_sticky,
  output logic [fill_w(N)-1:0] fill
);

  localparam int FW = fill_w(N);

  logic [N-1:0]  pattern;
  logic [N-1:0]  mask;
  logic [N-1:0]  next_hist;
  logic [FW-1:0] next_fill;
  logic          shift;
  logic          match;

  // A config load discards the bit on that edge, so it also suppresses matching
  assign shift = xin_valid & ~cfg_load;
  assign match = shift & (next_fill == FW'(N)) &
                 (((next_hist ^ pattern) & mask) == '0);

  seq_det_hist #(.N(N)) u_hist (
    .clk       (clk),
    .reset     (reset),
    .shift     (shift),
    .clear     (cfg_load),
    .restart   (match & ~overlap_en),
    .xin       (xin),
    .fill      (fill),
    .next_hist (next_hist),
    .next_fill (next_fill)
  );

  // Run-time pattern/mask registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= DEF_PATTERN;
      mask    <= DEF_MASK;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      mask    <= cfg_mask;
    end
  end

  // One-cycle registered match pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) yout <= 1'b0;
    else       yout <= match;
  end

  // Statistics: clear wins over count, but a same-edge match still sets sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt  <= '0;
      hit_sticky <= 1'b0;
    end else begin
      if (clr_stat)   match_cnt <= '0;
      else if (match) match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_W));
      if (match)         hit_sticky <= 1'b1;
      else if (clr_stat) hit_sticky <= 1'b0;
    end
  end

endmodule
